spi_register_bridge: RTL
========================

# spi_register_bridge

SPI peripheral (mode 0, MSB first) that turns 32-bit host frames into single-cycle register write strobes for the synth core. It drives the core's register number, register value and write-enable inputs. It also shifts the previously committed frame back out on MISO so the host can verify its writes. It sits between the board-level SPI pins and the synth top level, in the i_Clock domain.

## Interface
- SYNC_STAGES, 2: flip-flop stages on each of i_Sclk, i_Mosi and i_CsN before edge detection. Legal values are ≥2.
- i_Clock  in  1  system clock; must be at least 8× the SCLK frequency.
- i_Reset  in  1  synchronous, active-high reset.
- i_Sclk  in  1  SPI clock, asynchronous, idles low.
- i_Mosi  in  1  SPI data from host, asynchronous.
- i_CsN  in  1  SPI chip select, active low, asynchronous.
- o_Miso  out  1  SPI data to host, registered.
- o_RegisterNumber  out  8  register address of the last committed frame.
- o_RegisterValue  out  24  register data of the last committed frame.
- o_RegisterWriteEnable  out  1  one-cycle write strobe.
- o_FrameError  out  1  one-cycle pulse when a frame is aborted short.

## Operation
- Frame format: 32 bits, MSB first. Bits [31:24] are the register number; bits [23:0] are the register value.
- Synchronization and edge detection:
  - SCLK, MOSI and CS_N each pass through SYNC_STAGES flops.
  - A previous-value register on synced SCLK and CS_N gives the rise, fall, CS-assert and CS-deassert detects.
- States:
  - IDLE:
    - On CS-assert: bit counter ← 0; MISO shift register ← echo word; o_Miso ← echo[31]; go to SHIFT.
  - SHIFT:
    - On SCLK rise: rx shift register ← {rx[30:0], mosi_synced}; counter++.
    - On SCLK fall: tx shift register shifts left; o_Miso ← new tx[31].
    - When the rise that brings the counter to 32 is detected: o_RegisterNumber ← rx[30:23], o_RegisterValue ← {rx[22:0], mosi}, o_RegisterWriteEnable ← 1 for one cycle, echo word ← the same 32 bits; go to DONE.
    - On CS-deassert with counter < 32: o_FrameError ← 1 for one cycle, no write, rx contents discarded; go to IDLE.
  - DONE:
    - Further SCLK edges are ignored (no second write, o_Miso held).
    - On CS-deassert: go to IDLE. No error is flagged.
- Boundary conditions:
  - Counter is 6 bits and never wraps, because DONE stops counting.
  - CS-deassert with counter == 0 (CS toggled, no clocks) is an abort: o_FrameError pulses.
  - CS-assert detected in the same cycle as an SCLK rise: the assert takes priority and that rise is not counted. Hosts must not violate the CS-to-SCLK setup.
  - SCLK edges while in IDLE are ignored.
- o_RegisterNumber and o_RegisterValue hold their values between strobes. They change only at commit.
- Echo word:
  - Reset value is 0.
  - It is the full 32 bits of the most recent committed frame.
  - It is returned on MISO during the next frame.
- Reset at any time: all state returns to IDLE and all outputs take their reset values.
  - A frame in progress is dropped without o_FrameError.
  - If CS_N is still low after reset, nothing happens until CS_N rises and falls again. IDLE waits for an assert edge, and the previous-CS register is reset to 1 only when synced CS_N is high.
  - Reset values: o_Miso 0, o_RegisterNumber 0, o_RegisterValue 0, o_RegisterWriteEnable 0, o_FrameError 0, echo 0, state IDLE, counter 0.

## Timing
- Edge detection latency: SYNC_STAGES i_Clock edges from the first i_Clock edge that samples the new pin level. The detect is combinational off the last sync stage and its previous value.
- Write strobe: o_RegisterWriteEnable is high on the i_Clock cycle after the 32nd rise is detected. With SYNC_STAGES=2 that is 3 i_Clock edges after the sampling edge. It stays high for exactly 1 cycle.
- Number, value and strobe update on the same edge. Consumers sample them together.
- o_Miso updates 1 cycle after the detected SCLK fall (SYNC_STAGES+1 i_Clock edges after the pin fall). MSB is valid SYNC_STAGES+1 edges after CS_N falls.
- Host requirements:
  - SCLK high and low phases each ≥ 4 i_Clock periods.
  - CS_N setup before the first rise ≥ 4 i_Clock periods.
  - CS_N high time ≥ 4 i_Clock periods.
- Throughput: at most one write per CS_N assertion.

## Test plan
- Reset, then a frame of 0x0212_3456 → one strobe with number 0x02 and value 0x123456. o_FrameError stays 0 and o_Miso shifts out 0x00000000.
- Two frames back to back (0x0112_3456, then 0x15FF_FFFF) → two strobes with the correct fields. The second frame's MISO returns 0x0112_3456.
- CS_N raised after 20 bits → o_FrameError pulses once, there is no strobe, o_RegisterNumber/Value are unchanged, and the next full frame commits correctly.
- 40 SCLK pulses in one CS_N window with the first 32 bits = 0x10AB_CDEF → exactly one strobe with 0x10/0xABCDEF. The trailing bits are ignored and there is no error.
- i_Reset asserted mid-frame (bit 16) while CS_N stays low and clocks continue → no strobe and no error. The next CS cycle commits normally.
- Strobe latency check with SYNC_STAGES=2 and SCLK = i_Clock/8 → strobe exactly 3 edges after the first i_Clock edge sampling the 32nd SCLK high. Pulse width is 1 cycle.

Source files
------------

// File: rtl/spi_register_bridge_if.sv
// SPI pin bundle plus the register-write port towards the synth core.
// The bridge uses the slave view; the SPI host side uses the master view.
interface spi_register_bridge_if;
   logic        i_Sclk;
   logic        i_Mosi;
   logic        i_CsN;
   logic        o_Miso;
   logic [7:0]  o_RegisterNumber;
   logic [23:0] o_RegisterValue;
   logic        o_RegisterWriteEnable;
   logic        o_FrameError;

   modport slave (
      input  i_Sclk,
      input  i_Mosi,
      input  i_CsN,
      output o_Miso,
      output o_RegisterNumber,
      output o_RegisterValue,
      output o_RegisterWriteEnable,
      output o_FrameError
   );

   modport master (
      output i_Sclk,
      output i_Mosi,
      output i_CsN,
      input  o_Miso,
      input  o_RegisterNumber,
      input  o_RegisterValue,
      input  o_RegisterWriteEnable,
      input  o_FrameError
   );
endinterface

// File: rtl/spi_register_bridge.sv
// SPI mode-0 peripheral: 32-bit frames become single-cycle register write
// strobes (number = bits 31:24, value = bits 23:0). The last committed frame
// is echoed back on MISO during the following frame.
module spi_register_bridge #(
   parameter int SYNC_STAGES = 2
) (
   input logic                  i_Clock,
   input logic                  i_Reset,
   spi_register_bridge_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   // Pin order inside the synchronizer bank: 0 = SCLK, 1 = MOSI, 2 = CS_N
   logic [2:0]             pins;
   logic [SYNC_STAGES-1:0] sync_reg [3];

   assign pins = {bus.i_CsN, bus.i_Mosi, bus.i_Sclk};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         // Plain shift-register synchronizer; left unreset so a low CS_N is
         // never mistaken for an assert edge when reset releases.
         always_ff @(posedge i_Clock) begin
            sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], pins[gi]};
         end
      end
   endgenerate

   logic sclk_s, mosi_s, csn_s;
   assign sclk_s = sync_reg[0][SYNC_STAGES-1];
   assign mosi_s = sync_reg[1][SYNC_STAGES-1];
   assign csn_s  = sync_reg[2][SYNC_STAGES-1];

   logic sclk_prev_reg;
   logic csn_prev_reg;

   logic sclk_rise, sclk_fall, cs_assert, cs_deassert;
   assign sclk_rise   =  sclk_s & ~sclk_prev_reg;
   assign sclk_fall   = ~sclk_s &  sclk_prev_reg;
   assign cs_assert   = ~csn_s  &  csn_prev_reg;
   assign cs_deassert =  csn_s  & ~csn_prev_reg;

   state_t      state_reg;
   logic [5:0]  count_reg;
   logic [30:0] rx_reg;     // first 31 received bits; the 32nd is taken live
   logic [30:0] tx_reg;     // echo bits still to be shifted out after o_Miso
   logic [31:0] echo_reg;
   logic        miso_reg;
   logic [7:0]  number_reg;
   logic [23:0] value_reg;
   logic        we_reg;
   logic        error_reg;

   // Previous-value registers: during reset they track the synced pins, so a
   // CS_N that is still low afterwards needs a fresh high-low edge.
   always_ff @(posedge i_Clock) begin
      sclk_prev_reg <= sclk_s;
      csn_prev_reg  <= csn_s;
   end

   // Frame FSM with all outputs registered
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_reg  <= ST_IDLE;
         count_reg  <= '0;
         rx_reg     <= '0;
         tx_reg     <= '0;
         echo_reg   <= '0;
         miso_reg   <= 1'b0;
         number_reg <= '0;
         value_reg  <= '0;
         we_reg     <= 1'b0;
         error_reg  <= 1'b0;
      end else begin
         we_reg    <= 1'b0;
         error_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // SCLK edges are ignored here, including one coincident with the assert
               if (cs_assert) begin
                  count_reg <= '0;
                  tx_reg    <= echo_reg[30:0];
                  miso_reg  <= echo_reg[31];
                  state_reg <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cs_deassert) begin
                  // Short frame: drop what was received and flag it
                  error_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end else begin
                  if (sclk_rise) begin
                     rx_reg    <= {rx_reg[29:0], mosi_s};
                     count_reg <= count_reg + 6'd1;
                     if (count_reg == 6'd31) begin
                        number_reg <= rx_reg[30:23];
                        value_reg  <= {rx_reg[22:0], mosi_s};
                        echo_reg   <= {rx_reg, mosi_s};
                        we_reg     <= 1'b1;
                        state_reg  <= ST_DONE;
                     end
                  end
                  if (sclk_fall) begin
                     miso_reg <= tx_reg[30];
                     tx_reg   <= {tx_reg[29:0], 1'b0};
                  end
               end
            end
            ST_DONE: begin
               // Trailing clocks are ignored; a normal end of frame is not an error
               if (cs_deassert) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_Miso                = miso_reg;
   assign bus.o_RegisterNumber      = number_reg;
   assign bus.o_RegisterValue       = value_reg;
   assign bus.o_RegisterWriteEnable = we_reg;
   assign bus.o_FrameError          = error_reg;

endmodule
